// File: rtl/spi_display_master_if.sv
// Write-request and SPI pin bundle for spi_display_master.
// The master modport belongs to the SPI master block; the slave modport belongs to the request feeder.
interface spi_display_master_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                          wr_valid_i;
  logic                          wr_ready_o;
  logic [3:0]                    wr_addr_i;
  logic [7:0]                    wr_data_i;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count_o;
  logic                          busy_o;
  logic                          err_o;
  logic                          spi_sclk_o;
  logic                          spi_ss_o;
  logic                          spi_mosi_o;

  modport master (
    input  wr_valid_i, wr_addr_i, wr_data_i,
    output wr_ready_o, fifo_count_o, busy_o, err_o, spi_sclk_o, spi_ss_o, spi_mosi_o
  );

  modport slave (
    output wr_valid_i, wr_addr_i, wr_data_i,
    input  wr_ready_o, fifo_count_o, busy_o, err_o, spi_sclk_o, spi_ss_o, spi_mosi_o
  );
endinterface

// File: rtl/spi_display_master.sv
// Queues display register writes and sends each one as a 16-bit SPI frame {4'b0001, addr, data}.
// Defining SPI_DISPLAY_ADDR_FILTER_EN drops writes to addresses above 9 and pulses err_o.
module spi_display_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input logic                  clock_i,
  input logic                  rst_i,
  spi_display_master_if.master bus
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HcMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned HcW   = $clog2(HcMax);
  localparam logic [HcW-1:0]  DivLast = HcW'(CLK_DIV - 1);
  localparam logic [HcW-1:0]  GapLast = HcW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] Full    = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StHold, StGap} state_e;

  logic [11:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, enq, pop, err_d, err_q;

  state_e          state_q, state_d;
  logic [HcW-1:0]  hc_q, hc_d;
  logic [3:0]      bi_q, bi_d;
  logic [15:0]     frame_q, frame_d;
  logic            sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d;

  assign bus.wr_ready_o = (count_q != Full);
  assign push           = bus.wr_valid_i && bus.wr_ready_o;
  assign pop            = (state_q == StIdle) && (count_q != '0);

`ifdef SPI_DISPLAY_ADDR_FILTER_EN
  // Out-of-range writes complete the handshake but never reach the queue.
  assign enq   = push && (bus.wr_addr_i <= 4'd9);
  assign err_d = push && (bus.wr_addr_i > 4'd9);
`else
  assign enq   = push;
  assign err_d = 1'b0;
`endif

  assign count_d = count_q + CntW'(enq) - CntW'(pop);

  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (enq) mem_q[wr_ptr_q] <= {bus.wr_addr_i, bus.wr_data_i};
  end

  // State and registered SPI pins; pins are loaded from the next-state decode.
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      hc_q    <= '0;
      bi_q    <= '0;
      frame_q <= '0;
      sclk_q  <= 1'b1;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      bi_q    <= bi_d;
      frame_q <= frame_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    bi_d    = bi_q;
    frame_d = frame_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          frame_d = {4'b0001, mem_q[rd_ptr_q]};
          bi_d    = 4'd15;
          hc_d    = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (hc_q == DivLast) begin
          hc_d    = '0;
          state_d = StLow;
        end else begin
          hc_d = hc_q + HcW'(1);
        end
      end
      StLow: begin
        if (hc_q == DivLast) begin
          hc_d    = '0;
          state_d = StHigh;
        end else begin
          hc_d = hc_q + HcW'(1);
        end
      end
      StHigh: begin
        if (hc_q == DivLast) begin
          hc_d = '0;
          if (bi_q == 4'd0) begin
            state_d = StHold;
          end else begin
            bi_d    = bi_q - 4'd1;
            state_d = StLow;
          end
        end else begin
          hc_d = hc_q + HcW'(1);
        end
      end
      StHold: begin
        if (hc_q == DivLast) begin
          hc_d    = '0;
          state_d = StGap;
        end else begin
          hc_d = hc_q + HcW'(1);
        end
      end
      StGap: begin
        if (hc_q == GapLast) begin
          hc_d    = '0;
          state_d = StIdle;
        end else begin
          hc_d = hc_q + HcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // mosi follows bi_d, so it moves on the first LOW cycle and is frozen through HIGH and HOLD.
  always_comb begin
    sclk_d = 1'b1;
    ss_d   = 1'b1;
    mosi_d = 1'b1;
    case (state_d)
      StSetup: begin
        ss_d   = 1'b0;
        mosi_d = frame_d[15];
      end
      StLow: begin
        ss_d   = 1'b0;
        sclk_d = 1'b0;
        mosi_d = frame_d[bi_d];
      end
      StHigh, StHold: begin
        ss_d   = 1'b0;
        mosi_d = frame_d[bi_d];
      end
      default: ;
    endcase
  end

  assign bus.fifo_count_o = count_q;
  assign bus.busy_o       = (count_q != '0) || (state_q != StIdle);
  assign bus.err_o        = err_q;
  assign bus.spi_sclk_o   = sclk_q;
  assign bus.spi_ss_o     = ss_q;
  assign bus.spi_mosi_o   = mosi_q;
endmodule

// File: tb/tb_spi_display_master.sv
// Directed bench for spi_display_master: a CLK_DIV=4 unit plus CLK_DIV=2 and 7 units for timing.
// A negedge monitor decodes every frame on each unit; checks run from the main sequence.
module tb_spi_display_master;
  localparam int Gap = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_display_master_if #(.FIFO_DEPTH(4)) bus0 ();
  spi_display_master_if #(.FIFO_DEPTH(4)) bus2 ();
  spi_display_master_if #(.FIFO_DEPTH(4)) bus7 ();

  spi_display_master #(.CLK_DIV(4), .FIFO_DEPTH(4), .GAP_CYCLES(Gap)) u_dut (
    .clock_i(clk), .rst_i(rst), .bus(bus0)
  );
  spi_display_master #(.CLK_DIV(2), .FIFO_DEPTH(4), .GAP_CYCLES(Gap)) u_dut2 (
    .clock_i(clk), .rst_i(rst), .bus(bus2)
  );
  spi_display_master #(.CLK_DIV(7), .FIFO_DEPTH(4), .GAP_CYCLES(Gap)) u_dut7 (
    .clock_i(clk), .rst_i(rst), .bus(bus7)
  );

  logic       v_valid [3];
  logic [3:0] v_addr  [3];
  logic [7:0] v_data  [3];
  logic       s_sclk [3], s_ss [3], s_mosi [3], s_ready [3];

  assign bus0.wr_valid_i = v_valid[0];
  assign bus0.wr_addr_i  = v_addr[0];
  assign bus0.wr_data_i  = v_data[0];
  assign bus2.wr_valid_i = v_valid[1];
  assign bus2.wr_addr_i  = v_addr[1];
  assign bus2.wr_data_i  = v_data[1];
  assign bus7.wr_valid_i = v_valid[2];
  assign bus7.wr_addr_i  = v_addr[2];
  assign bus7.wr_data_i  = v_data[2];

  assign s_sclk[0] = bus0.spi_sclk_o;  assign s_ss[0] = bus0.spi_ss_o;
  assign s_mosi[0] = bus0.spi_mosi_o;  assign s_ready[0] = bus0.wr_ready_o;
  assign s_sclk[1] = bus2.spi_sclk_o;  assign s_ss[1] = bus2.spi_ss_o;
  assign s_mosi[1] = bus2.spi_mosi_o;  assign s_ready[1] = bus2.wr_ready_o;
  assign s_sclk[2] = bus7.spi_sclk_o;  assign s_ss[2] = bus7.spi_ss_o;
  assign s_mosi[2] = bus7.spi_mosi_o;  assign s_ready[2] = bus7.wr_ready_o;

  function automatic int div_of(input int k);
    if (k == 0) return 4;
    if (k == 1) return 2;
    return 7;
  endfunction

  // Frame monitor state, per unit.
  int          cyc = 0;
  int          nfrm [3] = '{0, 0, 0};
  logic [15:0] frm [3][10];
  int          low_len [3][10];
  int          edges [3][10];
  int          fall_cyc [3][10];
  int          phase_bad [3] = '{0, 0, 0};
  int          mosi_bad [3] = '{0, 0, 0};
  int          peak = 0;
  int          full_bad = 0;
  logic        p_sclk [3] = '{1'b1, 1'b1, 1'b1};
  logic        p_ss [3] = '{1'b1, 1'b1, 1'b1};
  logic        p_mosi [3] = '{1'b1, 1'b1, 1'b1};
  int          run [3] = '{0, 0, 0};
  int          lowc [3] = '{0, 0, 0};
  int          ec [3] = '{0, 0, 0};
  int          fc [3] = '{0, 0, 0};
  logic [15:0] sh [3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (32'(bus0.fifo_count_o) > peak) peak <= 32'(bus0.fifo_count_o);
    if (bus0.fifo_count_o == 3'd4 && bus0.wr_ready_o) full_bad <= full_bad + 1;
    for (int k = 0; k < 3; k++) begin
      if (!s_ss[k]) begin
        if (p_ss[k]) begin
          sh[k]   <= '0;
          lowc[k] <= 1;
          ec[k]   <= 0;
          run[k]  <= 1;
          fc[k]   <= cyc;
        end else begin
          lowc[k] <= lowc[k] + 1;
          if (s_sclk[k] != p_sclk[k]) begin
            if (run[k] != div_of(k)) phase_bad[k] <= phase_bad[k] + 1;
            run[k] <= 1;
          end else begin
            run[k] <= run[k] + 1;
          end
          if (s_sclk[k] && !p_sclk[k]) begin
            sh[k] <= {sh[k][14:0], s_mosi[k]};
            ec[k] <= ec[k] + 1;
          end
          if (s_sclk[k] && p_sclk[k] && (s_mosi[k] != p_mosi[k])) mosi_bad[k] <= mosi_bad[k] + 1;
        end
      end else if (!p_ss[k] && nfrm[k] < 10) begin
        frm[k][nfrm[k]]      <= sh[k];
        low_len[k][nfrm[k]]  <= lowc[k];
        edges[k][nfrm[k]]    <= ec[k];
        fall_cyc[k][nfrm[k]] <= fc[k];
        nfrm[k]              <= nfrm[k] + 1;
      end
      p_sclk[k] <= s_sclk[k];
      p_ss[k]   <= s_ss[k];
      p_mosi[k] <= s_mosi[k];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic push(input int k, input logic [3:0] a, input logic [7:0] d, output int waits);
    v_addr[k]  = a;
    v_data[k]  = d;
    v_valid[k] = 1'b1;
    waits      = 0;
    while (!s_ready[k] && waits < 2000) begin
      @(posedge clk);
      @(negedge clk);
      waits++;
    end
    if (waits >= 2000) bound_fail("push_handshake");
    @(posedge clk);
    @(negedge clk);
    v_valid[k] = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int n);
    int t;
    t = 0;
    while (nfrm[k] < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (nfrm[k] < n) bound_fail("frame_wait");
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
  } vec_t;

  vec_t tbl [6];
  int   order [6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    int w, stall, t, rises, bad, n;
    logic prev;

    tbl[0] = '{addr: 4'd0, data: 8'hFF, frame: 16'h10FF};
    tbl[1] = '{addr: 4'd1, data: 8'h01, frame: 16'h1101};
    tbl[2] = '{addr: 4'd2, data: 8'h02, frame: 16'h1202};
    tbl[3] = '{addr: 4'd3, data: 8'h03, frame: 16'h1303};
    tbl[4] = '{addr: 4'd4, data: 8'h04, frame: 16'h1404};
    tbl[5] = '{addr: 4'd9, data: 8'hA0, frame: 16'h19A0};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v_valid[k] = 1'b0;
      v_addr[k]  = '0;
      v_data[k]  = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_sclk",  32'(bus0.spi_sclk_o), 1);
    check("rst_ss",    32'(bus0.spi_ss_o), 1);
    check("rst_mosi",  32'(bus0.spi_mosi_o), 1);
    check("rst_count", 32'(bus0.fifo_count_o), 0);
    check("rst_ready", 32'(bus0.wr_ready_o), 1);
    check("rst_busy",  32'(bus0.busy_o), 0);
    check("rst_err",   32'(bus0.err_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame, then the gap and the return to idle.
    push(0, tbl[0].addr, tbl[0].data, w);
    t = 0;
    while (s_ss[0] && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (!s_ss[0] && t < 400) begin @(negedge clk); t++; end
    if (!s_ss[0]) bound_fail("ss_release");
    repeat (Gap - 1) @(negedge clk);
    check("busy_last_gap_cycle", 32'(bus0.busy_o), 1);
    @(negedge clk);
    check("busy_idle", 32'(bus0.busy_o), 0);
    check("idle_sclk", 32'(bus0.spi_sclk_o), 1);
    check("idle_ss",   32'(bus0.spi_ss_o), 1);
    check("idle_mosi", 32'(bus0.spi_mosi_o), 1);
    wait_frames(0, 1);
    check("f0_frame", 32'(frm[0][0]), 32'(tbl[0].frame));
    check("f0_ss_low", low_len[0][0], 136);
    check("f0_edges", edges[0][0], 16);

    // Back-to-back queue, the last request stalls against a full FIFO.
    for (int i = 0; i < 6; i++) begin
      push(0, tbl[order[i]].addr, tbl[order[i]].data, w);
      if (i == 5) stall = w;
    end
    check("stall_at_least_50", 32'(stall >= 50), 1);
    wait_frames(0, 7);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("q%0d_frame", i), 32'(frm[0][1 + i]), 32'(tbl[order[i]].frame));
      check($sformatf("q%0d_edges", i), edges[0][1 + i], 16);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("q%0d_period", i), fall_cyc[0][2 + i] - fall_cyc[0][1 + i], 145);
    end
    check("count_peak", peak, 4);
    check("ready_low_when_full", full_bad, 0);
    t = 0;
    while (bus0.busy_o && t < 400) begin @(negedge clk); t++; end
    check("busy_drained", 32'(bus0.busy_o), 0);

    // Reset after the 7th rising edge aborts the frame and flushes the queue.
    push(0, tbl[1].addr, tbl[1].data, w);
    push(0, tbl[2].addr, tbl[2].data, w);
    rises = 0;
    prev  = s_sclk[0];
    t     = 0;
    while (rises < 7 && t < 500) begin
      @(negedge clk);
      if (s_sclk[0] && !prev) rises++;
      prev = s_sclk[0];
      t++;
    end
    check("rises_before_reset", rises, 7);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ss",    32'(bus0.spi_ss_o), 1);
    check("mid_rst_sclk",  32'(bus0.spi_sclk_o), 1);
    check("mid_rst_mosi",  32'(bus0.spi_mosi_o), 1);
    check("mid_rst_count", 32'(bus0.fifo_count_o), 0);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (!s_sclk[0] || !s_ss[0]) bad++;
    end
    check("quiet_after_reset", bad, 0);
    check("busy_after_reset", 32'(bus0.busy_o), 0);

    // Address above 9.
    @(posedge clk);
    n = nfrm[0];
    @(negedge clk);
    push(0, 4'd12, 8'h55, w);
`ifdef SPI_DISPLAY_ADDR_FILTER_EN
    check("bad_addr_err", 32'(bus0.err_o), 1);
    check("bad_addr_count", 32'(bus0.fifo_count_o), 0);
    @(negedge clk);
    check("bad_addr_err_clear", 32'(bus0.err_o), 0);
    repeat (200) @(posedge clk);
    check("bad_addr_no_frame", nfrm[0], n);
    @(negedge clk);
    push(0, tbl[5].addr, tbl[5].data, w);
    wait_frames(0, n + 1);
    check("addr9_frame", 32'(frm[0][n]), 32'(tbl[5].frame));
`else
    check("addr12_err", 32'(bus0.err_o), 0);
    @(negedge clk);
    check("addr12_err_next", 32'(bus0.err_o), 0);
    wait_frames(0, n + 1);
    check("addr12_frame", 32'(frm[0][n]), 32'h1C55);
`endif

    // Clock-divider sweep.
    push(1, 4'd3, 8'h5A, w);
    push(2, 4'd3, 8'h5A, w);
    wait_frames(1, 1);
    wait_frames(2, 1);
    for (int k = 1; k < 3; k++) begin
      check($sformatf("div%0d_frame", div_of(k)), 32'(frm[k][0]), 32'h135A);
      check($sformatf("div%0d_ss_low", div_of(k)), low_len[k][0], 34 * div_of(k));
      check($sformatf("div%0d_edges", div_of(k)), edges[k][0], 16);
      check($sformatf("div%0d_phase", div_of(k)), phase_bad[k], 0);
      check($sformatf("div%0d_mosi_stable", div_of(k)), mosi_bad[k], 0);
    end
    check("div4_phase", phase_bad[0], 0);
    check("div4_mosi_stable", mosi_bad[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end
endmodule
